lc3_mem_model: RTL and testbench

- Synthesizable word-addressed LC-3 main memory with a variable-latency ready handshake.
- Sits directly downstream of the CPU datapath's memory port: consumes mem_we/mem_re/mem_addr/mem_wdata and produces mem_rdata/mem_ready, the memory-side signals the TB monitor samples.
- A backdoor load port lets the TB preload programs (e.g. the bubble-sort image) while the CPU is held in reset.
- Includes saturating access counters for coverage/scoreboarding.

---
 rtl/lc3_mem_model.sv | 165 ++++++++++++++++
 tb/tb_lc3_mem_model.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_model.sv
// LC-3 word-addressed main memory with variable-latency ready handshake.
// Optional display MMIO (DSR/DDR) decode enabled by LC3_MEM_MMIO_EN.
module lc3_mem_model #(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_we,
  input  logic             mem_re,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_wdata,
  output logic [15:0]      mem_rdata,
  output logic             mem_ready,
  input  logic             load_en,
  input  logic [15:0]      load_addr,
  input  logic [15:0]      load_data,
  output logic             req_err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [15:0]      ddr_data,
  output logic             ddr_valid
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [3:0]             lat_q;
  logic [15:0]            addr_q;
  logic [15:0]            wdata_q;
  logic                   we_q;
  logic                   req;
  logic                   accept;
  logic                   finish;
  logic                   is_dsr;
  logic                   is_ddr;
  logic [15:0]            rd_val;
  logic                   arr_we;
  logic [ADDR_BITS-1:0]   arr_waddr;
  logic [15:0]            arr_wdata;
  logic [ADDR_BITS-1:0]   idx;
  logic [15:0]            arr [DEPTH];
  logic                   unused_hi;

  assign req       = mem_we | mem_re;
  assign idx       = addr_q[ADDR_BITS-1:0];
  assign mem_ready = (state_q == DONE);
  assign unused_hi = ^{addr_q, load_addr};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          accept  = 1'b1;
        end
      end
      BUSY: begin
        if (lat_q == 4'd0) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef LC3_MEM_MMIO_EN
  logic [15:0] ddr_q;

  assign is_dsr    = (addr_q == 16'hFE04);
  assign is_ddr    = (addr_q == 16'hFE06);
  assign ddr_data  = ddr_q;
  assign ddr_valid = mem_ready & we_q & is_ddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ddr_q <= '0;
    end else if (finish && we_q && is_ddr) begin
      ddr_q <= wdata_q;
    end
  end

  always_comb begin
    rd_val = arr[idx];
    if (is_dsr) rd_val = 16'h8000;
    else if (is_ddr) rd_val = ddr_q;
  end
`else
  assign is_dsr    = 1'b0;
  assign is_ddr    = 1'b0;
  assign ddr_data  = '0;
  assign ddr_valid = 1'b0;

  always_comb begin
    rd_val = arr[idx];
    if (is_dsr) rd_val = 16'h8000;
  end
`endif

  // CPU commit wins; backdoor only when IDLE with no request
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = load_addr[ADDR_BITS-1:0];
    arr_wdata = load_data;
    if (finish && we_q && !is_ddr) begin
      arr_we    = 1'b1;
      arr_waddr = idx;
      arr_wdata = wdata_q;
    end else if (state_q == IDLE && !req && load_en) begin
      arr_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) arr[arr_waddr] <= arr_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      mem_rdata <= '0;
      req_err   <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        we_q    <= mem_we;
        lat_q   <= LAT_M1;
        if (mem_we && mem_re) req_err <= 1'b1;
      end else if (state_q == BUSY && lat_q != 4'd0) begin
        lat_q <= lat_q - 4'd1;
      end
      if (finish) begin
        if (we_q) begin
          if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
        end else begin
          mem_rdata <= rd_val;
          if (rd_count != '1) rd_count <= rd_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_model.sv
// Directed plus randomized bench for lc3_mem_model against a word-array model.
// Expectations follow the MMIO decode when LC3_MEM_MMIO_EN is defined.
module tb_lc3_mem_model;

  localparam int LAT = 3;
  localparam int CW  = 16;
`ifdef LC3_MEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_we = 1'b0;
  logic          mem_re = 1'b0;
  logic [15:0]   mem_addr = '0;
  logic [15:0]   mem_wdata = '0;
  logic [15:0]   mem_rdata;
  logic          mem_ready;
  logic          load_en = 1'b0;
  logic [15:0]   load_addr = '0;
  logic [15:0]   load_data = '0;
  logic          req_err;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;
  logic [15:0]   ddr_data;
  logic          ddr_valid;

  always #5 clk = ~clk;

  lc3_mem_model #(
    .ADDR_BITS(12),
    .LATENCY(LAT),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .req_err(req_err),
    .rd_count(rd_count),
    .wr_count(wr_count),
    .ddr_data(ddr_data),
    .ddr_valid(ddr_valid)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] mdl [0:4095];
  logic [15:0] ddr_m = '0;
  logic [15:0] last_rd = '0;
  int          exp_rd = 0;
  int          exp_wr = 0;
  logic        exp_err = 1'b0;
  logic [15:0] alt_addr = '0;
  logic [15:0] alt_wdata = '0;
  logic        seen_dv;
  logic [11:0] lows[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void mwrite(input logic [15:0] a, input logic [15:0] d);
    if (MMIO && a == 16'hFE06) ddr_m = d;
    else mdl[a[11:0]] = d;
  endfunction

  function automatic logic [15:0] mread(input logic [15:0] a);
    if (MMIO && a == 16'hFE04) return 16'h8000;
    if (MMIO && a == 16'hFE06) return ddr_m;
    return mdl[a[11:0]];
  endfunction

  task automatic backdoor(input logic [15:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    mdl[a[11:0]] = d;
  endtask

  // mode 1: change addr/data mid-BUSY; 2: load_en mid-BUSY;
  // 3: load_en together with the request in IDLE
  task automatic access(input logic we, input logic re,
                        input logic [15:0] a, input logic [15:0] wd,
                        input int mode, output logic [15:0] rd,
                        output int lat);
    mem_we    = we;
    mem_re    = re;
    mem_addr  = a;
    mem_wdata = wd;
    if (mode == 3) begin
      load_en   = 1'b1;
      load_addr = alt_addr;
      load_data = alt_wdata;
    end
    lat = 0;
    seen_dv = 1'b0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && mode == 1) begin
        mem_addr  = alt_addr;
        mem_wdata = alt_wdata;
      end
      if (lat == 1 && mode == 2) begin
        load_en   = 1'b1;
        load_addr = alt_addr;
        load_data = alt_wdata;
      end
      if (lat == 2 || mode == 3) load_en = 1'b0;
      if (mem_ready) break;
    end
    if (lat >= 50) check("ready_timeout", mem_ready, 1'b1);
    rd      = mem_rdata;
    seen_dv = ddr_valid;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    load_en = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", mem_ready, 1'b0);
  endtask

  task automatic op(input logic we, input logic re, input logic [15:0] a,
                    input logic [15:0] wd, input int mode, input string tag);
    logic [15:0] rd;
    int          lat;
    logic [15:0] e;
    access(we, re, a, wd, mode, rd, lat);
    check({tag, ":latency"}, lat, LAT + 1);
    if (we) begin
      mwrite(a, wd);
      exp_wr++;
      if (re) exp_err = 1'b1;
      check({tag, ":rdata_hold"}, rd, last_rd);
      check({tag, ":ddr_valid"}, seen_dv, MMIO && a == 16'hFE06);
    end else begin
      e = mread(a);
      exp_rd++;
      last_rd = e;
      check({tag, ":rdata"}, rd, e);
      check({tag, ":ddr_valid"}, seen_dv, 1'b0);
    end
    check({tag, ":rd_count"}, rd_count, exp_rd);
    check({tag, ":wr_count"}, wr_count, exp_wr);
    check({tag, ":req_err"}, req_err, exp_err);
    check({tag, ":ddr_data"}, ddr_data, ddr_m);
  endtask

  initial begin
    logic [11:0] lo;
    logic [15:0] a;
    int          kind;
    int          md;

    @(negedge clk);
    check("rst_rdata", mem_rdata, 16'h0);
    check("rst_ready", mem_ready, 1'b0);
    check("rst_err", req_err, 1'b0);
    check("rst_rdcnt", rd_count, 0);
    check("rst_wrcnt", wr_count, 0);
    check("rst_ddr", ddr_data, 16'h0);
    check("rst_ddrv", ddr_valid, 1'b0);
    backdoor(16'h3000, 16'h1234);
    backdoor(16'h3003, 16'h0303);
    backdoor(16'h3005, 16'hCAFE);
    backdoor(16'h3006, 16'h0606);
    backdoor(16'h0E06, 16'h0E0E);
    rst_n = 1'b1;
    @(negedge clk);

    op(1'b0, 1'b1, 16'h3000, 16'h0, 0, "rd3000");
    op(1'b1, 1'b0, 16'h3001, 16'hBEEF, 0, "wr3001");
    op(1'b0, 1'b1, 16'h3001, 16'h0, 0, "rd3001");

    alt_addr  = 16'h3005;
    alt_wdata = 16'h6666;
    op(1'b1, 1'b0, 16'h3004, 16'h5555, 1, "wr_busychg");
    op(1'b0, 1'b1, 16'h3004, 16'h0, 0, "rd3004");
    op(1'b0, 1'b1, 16'h3005, 16'h0, 0, "rd3005");

    op(1'b1, 1'b1, 16'h3002, 16'h0042, 0, "both3002");
    op(1'b0, 1'b1, 16'h3002, 16'h0, 0, "rd3002");

    op(1'b1, 1'b0, 16'h1005, 16'hAAAA, 0, "wr1005");
    op(1'b0, 1'b1, 16'h0005, 16'h0, 0, "rd0005_alias");

    alt_addr  = 16'h3001;
    alt_wdata = 16'h9999;
    op(1'b0, 1'b1, 16'h3000, 16'h0, 2, "ld_in_busy");
    op(1'b0, 1'b1, 16'h3001, 16'h0, 0, "rd3001_after_ld");
    alt_addr = 16'h3006;
    op(1'b0, 1'b1, 16'h3000, 16'h0, 3, "ld_with_req");
    op(1'b0, 1'b1, 16'h3006, 16'h0, 0, "rd3006");

    op(1'b1, 1'b0, 16'hFE06, 16'h0041, 0, "wrFE06");
    op(1'b0, 1'b1, 16'h0E06, 16'h0, 0, "rd0E06");
    op(1'b0, 1'b1, 16'hFE06, 16'h0, 0, "rdFE06");
    op(1'b0, 1'b1, 16'hFE04, 16'h0, 0, "rdFE04");

    for (int i = 0; i < 40; i++) begin
      kind = (lows.size() == 0) ? 0 : int'($urandom_range(0, 2));
      md   = int'($urandom_range(0, 2));
      lo   = 12'h100 + 12'($urandom_range(0, 31));
      alt_addr  = {4'($urandom), 12'h100 + 12'($urandom_range(0, 31))};
      alt_wdata = 16'($urandom);
      if (kind == 0) begin
        a = {4'($urandom), lo};
        op(1'b1, 1'b0, a, 16'($urandom), md, "rand_wr");
        lows.push_back(lo);
      end else if (kind == 1) begin
        lo = lows[$urandom_range(0, lows.size() - 1)];
        a  = {4'($urandom), lo};
        op(1'b0, 1'b1, a, 16'h0, md, "rand_rd");
      end else begin
        backdoor({4'($urandom), lo}, 16'($urandom));
        lows.push_back(lo);
      end
    end

    mem_we    = 1'b1;
    mem_addr  = 16'h3003;
    mem_wdata = 16'h7777;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b0;
    mem_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_ready", mem_ready, 1'b0);
      @(negedge clk);
    end
    check("rst2_err", req_err, 1'b0);
    check("rst2_rdcnt", rd_count, 0);
    check("rst2_rdata", mem_rdata, 16'h0);
    rst_n   = 1'b1;
    exp_rd  = 0;
    exp_wr  = 0;
    exp_err = 1'b0;
    last_rd = '0;
    ddr_m   = '0;
    @(negedge clk);
    op(1'b0, 1'b1, 16'h3003, 16'h0, 0, "rd3003_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
